modbus_reg_access: RTL and testbench

//  Register-access engine on the system side of a dual-port register RAM port.

---
 rtl/modbus_reg_access.sv | 179 +++++++++++++++++
 tb/tb_modbus_reg_access.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modbus_reg_access.sv
// Modbus read/write-multiple-register engine driving one port of a dual-port register RAM.
// Optional start+quantity bounds check against REG_LIMIT: define MB_REG_BOUNDS_CHECK_EN.
module modbus_reg_access #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_QTY    = 125,
  parameter int REG_LIMIT  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_v,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [7:0]            req_qty,
  output logic                  busy,
  input  logic [DATA_WIDTH-1:0] wr_d,
  input  logic                  wr_v,
  output logic                  wr_rdy,
  output logic [DATA_WIDTH-1:0] rd_d,
  output logic                  rd_v,
  input  logic                  rd_rdy,
  output logic                  rd_last,
  output logic                  done,
  output logic [1:0]            err,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [DATA_WIDTH-1:0] ram_d,
  output logic                  ram_w,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    RD_ISSUE,
    RD_WAIT,
    RD_OUT,
    WR_ACC,
    WR_PULSE,
    DONE
  } state_t;

  localparam logic [7:0]          MAX_QTY_W   = 8'(MAX_QTY);
  localparam logic [ADDR_WIDTH:0] REG_LIMIT_W = (ADDR_WIDTH+1)'(REG_LIMIT);

`ifdef MB_REG_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  state_t                state;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            cnt_q;

  logic [ADDR_WIDTH:0]   end_addr;
  logic                  qty_bad;
  logic                  addr_bad;

  // End address is one bit wider than the RAM address so it never wraps.
  always_comb begin
    end_addr = {1'b0, addr_q} + (ADDR_WIDTH+1)'(cnt_q);
    qty_bad  = (cnt_q == 8'd0) || (cnt_q > MAX_QTY_W);
    addr_bad = BOUNDS_EN && (end_addr > REG_LIMIT_W);
  end

  // NOTE: all state and outputs use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      wr_rdy  <= 1'b0;
      rd_v    <= 1'b0;
      rd_last <= 1'b0;
      done    <= 1'b0;
      ram_w   <= 1'b0;
      err     <= 2'd0;
      ram_a   <= '0;
      ram_d   <= '0;
      rd_d    <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_v) begin
            wr_q   <= req_wr;
            addr_q <= req_addr;
            cnt_q  <= req_qty;
            busy   <= 1'b1;
            state  <= CHECK;
          end
        end

        CHECK: begin
          if (qty_bad) begin
            err   <= 2'd3;
            done  <= 1'b1;
            state <= DONE;
          end else if (addr_bad) begin
            err   <= 2'd2;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            err <= 2'd0;
            if (wr_q) begin
              wr_rdy <= 1'b1;
              state  <= WR_ACC;
            end else begin
              state <= RD_ISSUE;
            end
          end
        end

        RD_ISSUE: begin
          ram_a <= addr_q;
          ram_w <= 1'b0;
          state <= RD_WAIT;
        end

        // ram_q is sampled one full cycle after ram_a was registered.
        RD_WAIT: begin
          rd_d    <= ram_q;
          rd_v    <= 1'b1;
          rd_last <= (cnt_q == 8'd1);
          state   <= RD_OUT;
        end

        RD_OUT: begin
          if (rd_rdy) begin
            rd_v    <= 1'b0;
            rd_last <= 1'b0;
            addr_q  <= addr_q + ADDR_WIDTH'(1);
            cnt_q   <= cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= RD_ISSUE;
            end
          end
        end

        WR_ACC: begin
          if (wr_v && wr_rdy) begin
            ram_a  <= addr_q;
            ram_d  <= wr_d;
            ram_w  <= 1'b1;
            wr_rdy <= 1'b0;
            state  <= WR_PULSE;
          end
        end

        WR_PULSE: begin
          ram_w  <= 1'b0;
          addr_q <= addr_q + ADDR_WIDTH'(1);
          cnt_q  <= cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            wr_rdy <= 1'b1;
            state  <= WR_ACC;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modbus_reg_access.sv
// Bench for modbus_reg_access: directed and randomized transactions checked against
// a word-level RAM model and the request legality rules.
module tb_modbus_reg_access;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_v = 1'b0;
  logic        req_wr = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_qty = '0;
  logic        busy;
  logic [15:0] wr_d = '0;
  logic        wr_v = 1'b0;
  logic        wr_rdy;
  logic [15:0] rd_d;
  logic        rd_v;
  logic        rd_rdy = 1'b0;
  logic        rd_last;
  logic        done;
  logic [1:0]  err;
  logic [15:0] ram_a;
  logic [15:0] ram_d;
  logic        ram_w;
  logic [15:0] ram_q = '0;

  always #5 clk = ~clk;

  modbus_reg_access dut (
    .clk      (clk),
    .rst      (rst),
    .req_v    (req_v),
    .req_wr   (req_wr),
    .req_addr (req_addr),
    .req_qty  (req_qty),
    .busy     (busy),
    .wr_d     (wr_d),
    .wr_v     (wr_v),
    .wr_rdy   (wr_rdy),
    .rd_d     (rd_d),
    .rd_v     (rd_v),
    .rd_rdy   (rd_rdy),
    .rd_last  (rd_last),
    .done     (done),
    .err      (err),
    .ram_a    (ram_a),
    .ram_d    (ram_d),
    .ram_w    (ram_w),
    .ram_q    (ram_q)
  );

  // Power-up RAM contents are a fixed function of the address.
  function automatic logic [15:0] init_word(input logic [15:0] a);
    return (a ^ 16'hA5C3) + {a[7:0], a[15:8]};
  endfunction

  logic [15:0] mem [65536];
  bit          mem_vld [65536];

  always @(posedge clk) begin
    if (ram_w) begin
      mem[ram_a]     <= ram_d;
      mem_vld[ram_a] <= 1'b1;
    end
  end

  always @(negedge clk) ram_q <= mem_vld[ram_a] ? mem[ram_a] : init_word(ram_a);

  // Reference model of what the register file should hold.
  logic [15:0] model_mem [65536];
  bit          model_vld [65536];

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    return model_vld[a] ? model_mem[a] : init_word(a);
  endfunction

  function automatic logic [1:0] exp_err(input logic [15:0] addr, input logic [7:0] qty);
    if (qty == 8'd0 || int'(qty) > 125) return 2'd3;
`ifdef MB_REG_BOUNDS_CHECK_EN
    if (int'(addr) + int'(qty) > 1024) return 2'd2;
`else
    if (addr === 16'hxxxx) return 2'd1;
`endif
    return 2'd0;
  endfunction

  // Bus monitor: logs RAM writes and accepted read words, counts protocol violations.
  logic [15:0] wlog_a [$];
  logic [15:0] wlog_d [$];
  logic [15:0] rlog_d [$];
  logic        rlog_last [$];
  int          overlap_cnt = 0;
  int          long_w_cnt = 0;
  int          unstable_cnt = 0;
  int          hold_cnt = 0;
  logic        prev_w = 1'b0;
  logic        prev_hold = 1'b0;
  logic        prev_last = 1'b0;
  logic [15:0] prev_d = '0;
  logic [15:0] prev_a = '0;

  always @(negedge clk) begin
    if (ram_w) begin
      wlog_a.push_back(ram_a);
      wlog_d.push_back(ram_d);
    end
    if (ram_w && rd_v) overlap_cnt++;
    if (ram_w && prev_w) long_w_cnt++;
    if (prev_hold && (!rd_v || rd_d !== prev_d || rd_last !== prev_last || ram_a !== prev_a))
      unstable_cnt++;
    if (rd_v && rd_rdy) begin
      rlog_d.push_back(rd_d);
      rlog_last.push_back(rd_last);
    end
    if (rd_v && !rd_rdy) hold_cnt++;
    prev_w    = ram_w;
    prev_hold = rd_v && !rd_rdy;
    prev_d    = rd_d;
    prev_last = rd_last;
    prev_a    = ram_a;
  end

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] wdata [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: rd_rdy always high, 1: random rd_rdy, 2: hold rd_rdy low for the first 10 valid cycles.
  task automatic run_txn(input string name, input bit wr, input logic [15:0] addr,
                         input logic [7:0] qty, input int mode, input bit poke);
    logic [1:0]  e_err;
    logic [1:0]  got_err;
    logic [15:0] a;
    bit          got;
    bit          hs;
    int          lat;
    int          bound;
    int          widx;
    int          stall_left;
    int          w0;
    int          r0;
    int          h0;
    int          nw;
    int          nr;
    e_err   = exp_err(addr, qty);
    got_err = 2'd0;
    if (wr && wdata.size() == 0)
      for (int i = 0; i < int'(qty); i++) wdata.push_back(16'($urandom));
    w0 = wlog_a.size();
    r0 = rlog_d.size();
    h0 = hold_cnt;
    bound = 40 + 40 * int'(qty);
    got = 1'b0;
    lat = 0;
    widx = 0;
    stall_left = (mode == 2) ? 10 : 0;

    @(posedge clk); #1;
    req_v    = 1'b1;
    req_wr   = wr;
    req_addr = addr;
    req_qty  = qty;
    rd_rdy   = (mode == 0);
    wr_v     = 1'b0;
    for (int cyc = 1; cyc <= bound; cyc++) begin
      @(negedge clk);
      hs = wr_v && wr_rdy;
      if (mode == 2 && rd_v && stall_left > 0) stall_left--;
      if (done) begin
        got = 1'b1;
        lat = cyc;
        got_err = err;
        break;
      end
      @(posedge clk); #1;
      req_v = poke && (cyc == 4);
      if (poke) begin
        req_wr   = ~wr;
        req_addr = ~addr;
        req_qty  = 8'd1;
      end
      if (hs) widx++;
      wr_v = (widx < wdata.size()) && ($urandom_range(0, 3) != 0);
      wr_d = (widx < wdata.size()) ? wdata[widx] : 16'($urandom);
      case (mode)
        0:       rd_rdy = 1'b1;
        1:       rd_rdy = 1'($urandom_range(0, 1));
        default: rd_rdy = (stall_left == 0);
      endcase
    end

    check({name, ":done_seen"}, 32'(got), 32'd1);
    check({name, ":err"}, 32'(got_err), 32'(e_err));
    if (e_err == 2'd3) check({name, ":err3_latency"}, 32'(lat <= 3), 32'd1);
    @(posedge clk); #1;
    req_v  = 1'b0;
    wr_v   = 1'b0;
    rd_rdy = 1'b0;
    @(negedge clk);
    check({name, ":busy_after_done"}, 32'(busy), 32'd0);
    check({name, ":done_one_cycle"}, 32'(done), 32'd0);

    nw = wlog_a.size() - w0;
    nr = rlog_d.size() - r0;
    check({name, ":write_count"}, 32'(nw), (e_err == 2'd0 && wr) ? 32'(qty) : 32'd0);
    check({name, ":read_count"}, 32'(nr), (e_err == 2'd0 && !wr) ? 32'(qty) : 32'd0);
    for (int i = 0; i < nw && i < wdata.size(); i++) begin
      a = addr + 16'(i);
      check({name, ":wr_addr"}, 32'(wlog_a[w0+i]), 32'(a));
      check({name, ":wr_data"}, 32'(wlog_d[w0+i]), 32'(wdata[i]));
    end
    for (int i = 0; i < nr && i < int'(qty); i++) begin
      a = addr + 16'(i);
      check({name, ":rd_data"}, 32'(rlog_d[r0+i]), 32'(model_rd(a)));
      check({name, ":rd_last"}, 32'(rlog_last[r0+i]), 32'(i == int'(qty) - 1));
    end
    if (e_err == 2'd0 && wr) begin
      for (int i = 0; i < int'(qty); i++) begin
        a = addr + 16'(i);
        model_mem[a] = wdata[i];
        model_vld[a] = 1'b1;
      end
    end
    if (mode == 2) check({name, ":stall_hold_cycles"}, 32'((hold_cnt - h0) >= 10), 32'd1);
    wdata.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          npulse;
    int          widx;
    int          w0;
    bit          hit;
    bit          hs;
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  qty;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset:busy", 32'(busy), 32'd0);
    check("reset:wr_rdy", 32'(wr_rdy), 32'd0);
    check("reset:rd_v", 32'(rd_v), 32'd0);
    check("reset:rd_last", 32'(rd_last), 32'd0);
    check("reset:done", 32'(done), 32'd0);
    check("reset:ram_w", 32'(ram_w), 32'd0);
    check("reset:err", 32'(err), 32'd0);
    check("reset:ram_a", 32'(ram_a), 32'd0);
    check("reset:ram_d", 32'(ram_d), 32'd0);
    check("reset:rd_d", 32'(rd_d), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    wdata = '{16'h00A1, 16'h00B2, 16'h00C3};
    run_txn("wr_10", 1'b1, 16'h0010, 8'd3, 0, 1'b0);
    run_txn("rd_10", 1'b0, 16'h0010, 8'd3, 0, 1'b0);
    wdata = '{16'h1234, 16'h5678};
    run_txn("wr_20", 1'b1, 16'h0020, 8'd2, 0, 1'b0);
    run_txn("rd_20", 1'b0, 16'h0020, 8'd2, 1, 1'b0);

    run_txn("qty0_wr", 1'b1, 16'h0005, 8'd0, 0, 1'b0);
    run_txn("qty126_rd", 1'b0, 16'h0005, 8'd126, 0, 1'b0);
    run_txn("qty125_rd", 1'b0, 16'h0100, 8'd125, 0, 1'b0);
    run_txn("stall_rd", 1'b0, 16'h0030, 8'd2, 2, 1'b0);

    run_txn("bound_1020_5", 1'b0, 16'd1020, 8'd5, 0, 1'b0);
    run_txn("bound_1020_4", 1'b0, 16'd1020, 8'd4, 0, 1'b0);
    run_txn("wrap_ffff", 1'b0, 16'hFFFF, 8'd2, 0, 1'b0);

    // Reset arrives while the second of four words is being written.
    w0 = wlog_a.size();
    npulse = 0;
    widx = 0;
    hit = 1'b0;
    @(posedge clk); #1;
    req_v = 1'b1; req_wr = 1'b1; req_addr = 16'h0040; req_qty = 8'd4;
    wr_v = 1'b1; wr_d = 16'hD000;
    for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
      @(negedge clk);
      hs = wr_v && wr_rdy;
      if (ram_w) npulse++;
      if (npulse == 2) begin
        rst = 1'b1;
        hit = 1'b1;
      end else begin
        @(posedge clk); #1;
        req_v = 1'b0;
        if (hs) widx++;
        wr_d = 16'hD000 + 16'(widx);
      end
    end
    check("rst_mid:reached_word2", 32'(hit), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_mid:ram_w", 32'(ram_w), 32'd0);
      check("rst_mid:busy", 32'(busy), 32'd0);
      check("rst_mid:done", 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid:idle_ignores_wr_v", 32'(ram_w), 32'd0);
    end
    @(posedge clk); #1;
    wr_v = 1'b0;
    check("rst_mid:write_count", 32'(wlog_a.size() - w0), 32'd2);
    model_mem[16'h0040] = 16'hD000; model_vld[16'h0040] = 1'b1;
    model_mem[16'h0041] = 16'hD001; model_vld[16'h0041] = 1'b1;
    run_txn("after_rst_rd", 1'b0, 16'h0040, 8'd4, 1, 1'b0);

    for (int t = 0; t < 8; t++) begin
      case ($urandom_range(0, 3))
        0:       addr = 16'($urandom);
        1:       addr = 16'd1000 + 16'($urandom_range(0, 40));
        2:       addr = 16'hFFF0 + 16'($urandom_range(0, 15));
        default: addr = 16'h0200 + 16'($urandom_range(0, 15));
      endcase
      case ($urandom_range(0, 9))
        0:       qty = 8'd0;
        1:       qty = 8'd126 + 8'($urandom_range(0, 129));
        default: qty = 8'($urandom_range(1, 6));
      endcase
      wr = 1'b1;
      run_txn("rnd_wr", wr, addr, qty, int'($urandom_range(0, 1)), 1'b1);
      run_txn("rnd_rd", ~wr, addr, qty, int'($urandom_range(0, 1)), 1'b1);
    end

    check("bus:ram_w_with_rd_v", 32'(overlap_cnt), 32'd0);
    check("bus:ram_w_multi_cycle", 32'(long_w_cnt), 32'd0);
    check("bus:rd_hold_unstable", 32'(unstable_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
